// File: rtl/priori_pkg.sv
// priori_pkg -- shared parameters and the priority-index helper for the
// priori registered priority encoder.
//   WIDTH      : number of request inputs (power of two, >= 2)
//   OUT_W      : width of the encoded index, $clog2(WIDTH)
//   prio_index : index of the highest set bit of a WIDTH-bit vector
package priori_pkg;

  localparam int WIDTH = 8;
  localparam int OUT_W = $clog2(WIDTH);

  // Descending-priority scan. Once the highest set bit is found, the
  // 'found' term masks every lower bit, so X/Z below it cannot disturb idx.
  function automatic logic [OUT_W-1:0] prio_index(input logic [WIDTH-1:0] din);
    logic [OUT_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && din[i]) begin
        idx   = OUT_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/priori_if.sv
// priori_if -- request/result bundle for the priori encoder.
//   en    : encoder enable (master -> slave)
//   Din   : request vector, bit WIDTH-1 highest priority (master -> slave)
//   Dout  : registered index of the highest set request (slave -> master)
//   valid : Dout reflects an enabled, non-zero request (slave -> master)
interface priori_if;
  import priori_pkg::*;

  logic             en;
  logic [WIDTH-1:0] Din;
  logic [OUT_W-1:0] Dout;
  logic             valid;

  modport master (output en, output Din, input  Dout, input  valid);
  modport slave  (input  en, input  Din, output Dout, output valid);
endinterface

// File: rtl/priori_core.sv
// priori_core -- purely combinational priority core.
//   din : request vector
//   idx : index of the highest set bit (0 when din is zero)
//   any : OR-reduction of din
module priori_core
  import priori_pkg::*;
(
  input  logic [WIDTH-1:0] din,
  output logic [OUT_W-1:0] idx,
  output logic             any
);

  assign idx = prio_index(din);
  assign any = |din;

endmodule

// File: rtl/priori.sv
// priori -- registered priority encoder with enable, one-cycle latency.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears Dout/valid immediately
//   bus   : priori_if.slave (en, Din in; Dout, valid out)
// The only state is the output register pair; each edge overwrites it with
// the result for the en/Din sampled at that edge.
module priori
  import priori_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  priori_if.slave  bus
);

  logic [OUT_W-1:0] idx;
  logic             any;
  logic [OUT_W-1:0] dout_d, dout_q;
  logic             valid_d, valid_q;

  priori_core u_core (
    .din (bus.Din),
    .idx (idx),
    .any (any)
  );

  // Disabled or empty requests both report index 0 with valid low, so a
  // consumer only needs to look at valid to tell them from a real bit 0.
  always_comb begin
    dout_d  = '0;
    valid_d = 1'b0;
    if (bus.en && any) begin
      dout_d  = idx;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Dout  = dout_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_priori.sv
// tb_priori -- directed and random self-checking bench for priori.
module tb_priori;
  import priori_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  priori_if bus ();

  priori dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OUT_W-1:0] d_exp, input logic v_exp);
    n_cmp++;
    assert (bus.Dout === d_exp && bus.valid === v_exp)
    else begin
      n_err++;
      $error("FAIL %s: got Dout=%0d valid=%b, expected Dout=%0d valid=%b",
             tag, bus.Dout, bus.valid, d_exp, v_exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // independent reference: last set bit in ascending scan
  function automatic logic [OUT_W-1:0] ref_idx(input logic [WIDTH-1:0] d);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int k = 0; k < WIDTH; k++)
      if (d[k] == 1'b1) r = OUT_W'(k);
    return r;
  endfunction

  initial begin
    logic [WIDTH-1:0] v;
    logic             r_en;
    logic [WIDTH-1:0] r_din;
    logic [OUT_W-1:0] e_d;
    logic             e_v;
    n_cmp = 0;
    n_err = 0;

    // ---- reset ----
    rst_n   = 1'b0;
    bus.en  = 1'b1;
    bus.Din = 8'h80;
    #2;
    check("reset_hold", 3'd0, 1'b0);
    step();
    check("reset_hold_edge", 3'd0, 1'b0);
    rst_n = 1'b1;
    step();
    check("reset_release", 3'd7, 1'b1);

    // async assertion mid-cycle, no edge in between
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_async", 3'd0, 1'b0);
    step();
    check("reset_async_held", 3'd0, 1'b0);
    rst_n = 1'b1;
    step();
    check("reset_rerelease", 3'd7, 1'b1);

    // ---- single-bit sweep ----
    for (int k = 0; k < WIDTH; k++) begin
      bus.en  = 1'b1;
      bus.Din = 8'(1 << k);
      step();
      check($sformatf("sweep_%0d", k), OUT_W'(k), 1'b1);
    end

    // ---- priority with don't-cares ----
    bus.Din = 8'b0001_0111;
    step();
    check("prio_0x17", 3'd4, 1'b1);
    v       = 8'b0000_0010;
    v[0]    = 1'bx;
    bus.Din = v;
    step();
    check("prio_bit0_x", 3'd1, 1'b1);
    bus.Din = 8'hFF;
    step();
    check("prio_ff", 3'd7, 1'b1);

    // ---- enable gating ----
    bus.Din = 8'b0010_0000;
    for (int k = 0; k < 6; k++) begin
      bus.en = k[0];
      step();
      if (k[0]) check($sformatf("en_gate_%0d", k), 3'd5, 1'b1);
      else      check($sformatf("en_gate_%0d", k), 3'd0, 1'b0);
    end

    // en=0 with a full vector
    bus.en  = 1'b0;
    bus.Din = 8'hFF;
    step();
    check("en_off_ff", 3'd0, 1'b0);

    // ---- zero vs bit 0 ----
    bus.en  = 1'b1;
    bus.Din = 8'h00;
    step();
    check("zero_in", 3'd0, 1'b0);
    bus.Din = 8'h01;
    step();
    check("bit0_in", 3'd0, 1'b1);

    // ---- random ----
    for (int n = 0; n < 1000; n++) begin
      r_en    = 1'($urandom_range(0, 1));
      r_din   = 8'($urandom);
      if (n % 16 == 0) r_din = '0;
      bus.en  = r_en;
      bus.Din = r_din;
      e_v     = r_en && (r_din != '0);
      e_d     = e_v ? ref_idx(r_din) : '0;
      step();
      check("random", e_d, e_v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/priori.md
Name: priori

Overview:
- Registered 8-to-3 priority encoder with enable.
- Reports the index of the highest-set bit of `Din`, plus a valid flag.
- Used as a request/interrupt index selector.
- One clock domain; output is registered with 1-cycle latency.

Parameters:
- WIDTH, 8, number of request inputs; must be a power of two and at least 2.
- OUT_W, $clog2(WIDTH) = 3, width of encoded index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  encoder enable, active-high
- Din  input  WIDTH  request vector; bit WIDTH-1 has highest priority
- Dout  output  OUT_W  encoded index of highest-priority set bit
- valid  output  1  high when Dout reflects an enabled, non-zero Din

Behaviour:
- Reset: rst_n low asynchronously forces Dout=0 and valid=0. Both outputs are held while rst_n is low.
- Release of reset is synchronous to the next rising clk edge. The first capture happens on the first rising edge with rst_n high.
- Combinational core: idx = the highest i with Din[i]=1. All bits below idx are don't-care.
  - Din=0000_0001 -> 0
  - Din=0000_001x -> 1
  - Din=1xxx_xxxx -> 7
- Register update on every rising clk (when not in reset):
  - en=1 and Din!=0 -> Dout<=idx, valid<=1.
  - en=1 and Din==0 -> Dout<=0, valid<=0.
  - en=0 -> Dout<=0, valid<=0, regardless of Din.
- Latency: Dout/valid reflect en/Din sampled at the previous rising edge. No throughput limit; a new result can be produced every cycle.
- X/Z on bits below the highest set bit must not affect Dout; the core is a descending-priority if/casez chain.
- X/Z on the highest set bit or above is undefined input; no requirement applies.
- Reset asserted mid-stream: outputs go to 0 immediately (asynchronously). No pending result survives reset.
- No internal state besides the output registers.

Decomposition:
- Package priori_pkg:
  - Localparam WIDTH default 8.
  - Localparam OUT_W.
  - Function prio_index(input logic [WIDTH-1:0]) returning OUT_W bits.
- Sub-module priori_core: purely combinational. Inputs Din; outputs idx and any (the OR of Din).
- Top-level priori holds the registers and the enable/valid logic.

Test Plan:
- Reset: rst_n=0 mid-cycle with Din=8'h80, en=1 -> Dout=0, valid=0 immediately, with no clock edge needed. After release plus one edge -> Dout=7, valid=1.
- Single-bit sweep: en=1, Din=1<<k for k=0..7 -> one cycle later Dout=k, valid=1.
- Priority with don't-cares: en=1, Din=8'b0001_0111 -> Dout=4.
  - Din=8'b0000_001x (bit0 driven X) -> Dout=1, valid=1.
  - Din=8'b1111_1111 -> Dout=7.
- Enable gating: alternate en=0/1 each cycle with Din=8'b0010_0000 -> Dout alternates 0/5 and valid alternates 0/1, each lagging by one cycle.
- Zero input: en=1, Din=0 -> Dout=0, valid=0. Distinguish from Din=8'h01 -> Dout=0, valid=1.
- Random: 1000 cycles of random en/Din checked against a reference model of the highest set bit, with a 1-cycle delayed compare.
